// File: rtl/pipe_control_unit.sv
// pipe_control_unit: ID/EX control stage of the RISC pipeline.
// Decodes the ID opcode, detects load-use hazards and taken-branch flushes,
// registers the EX control bundle and keeps saturating stall/flush counters.
//
// Handshake note: there is no valid/ready pair here. id_valid qualifies the ID
// slot; stall asks upstream to hold PC and IF/ID; flush and jump_flush ask
// upstream to squash. The block never back-pressures through any other signal.
module pipe_control_unit #(
    parameter int OPCODE_W  = 4,
    parameter int RADDR_W   = 3,
    parameter int NUM_RTYPE = 5,
    parameter int OP_BRANCH = 5,
    parameter int OP_LOAD   = 6,
    parameter int OP_STORE  = 7,
    parameter int OP_JUMP   = 8,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [OPCODE_W-1:0] id_opcode,
    input  logic [RADDR_W-1:0]  id_rs1,
    input  logic [RADDR_W-1:0]  id_rs2,
    input  logic [RADDR_W-1:0]  id_rd,
    input  logic                ex_branch_taken,
    input  logic                cnt_clr,
    output logic                stall,
    output logic                flush,
    output logic                jump_flush,
    output logic                ex_valid,
    output logic                ex_reg_write,
    output logic                ex_branch,
    output logic                ex_alu_src,
    output logic                ex_load,
    output logic                ex_mem_write,
    output logic                ex_jump,
    output logic                ex_illegal,
    output logic [RADDR_W-1:0]  ex_rd,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    flush_cnt
);

    // Opcode constants sized to the opcode field so compares are width-clean.
    localparam logic [OPCODE_W-1:0] RTYPE_LIM = OPCODE_W'(NUM_RTYPE);
    localparam logic [OPCODE_W-1:0] OPC_BR    = OPCODE_W'(OP_BRANCH);
    localparam logic [OPCODE_W-1:0] OPC_LD    = OPCODE_W'(OP_LOAD);
    localparam logic [OPCODE_W-1:0] OPC_ST    = OPCODE_W'(OP_STORE);
    localparam logic [OPCODE_W-1:0] OPC_JMP   = OPCODE_W'(OP_JUMP);
    localparam logic [CNT_W-1:0]    CNT_MAX   = '1;

    // Decoded ID controls.
    logic dec_reg_write, dec_branch, dec_alu_src, dec_load;
    logic dec_mem_write, dec_jump, dec_illegal;
    logic dec_reads_rs1, dec_reads_rs2;

    // EX bundle state, bit order {valid, reg_write, branch, alu_src, load, mem_write, jump, illegal}.
    logic [7:0]         ctrl_q, ctrl_d;
    logic [RADDR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic load_use_hit;

    // Opcode decode; an empty ID slot decodes to all-zero controls and is not illegal.
    always_comb begin
        dec_reg_write = 1'b0;
        dec_branch    = 1'b0;
        dec_alu_src   = 1'b0;
        dec_load      = 1'b0;
        dec_mem_write = 1'b0;
        dec_jump      = 1'b0;
        dec_illegal   = 1'b0;
        dec_reads_rs1 = 1'b0;
        dec_reads_rs2 = 1'b0;
        if (id_valid) begin
            if (id_opcode < RTYPE_LIM) begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_reads_rs1 = 1'b1;
                dec_reads_rs2 = 1'b1;
            end else if (id_opcode == OPC_BR) begin
                dec_branch    = 1'b1;
                dec_alu_src   = 1'b1;
                dec_reads_rs1 = 1'b1;
                dec_reads_rs2 = 1'b1;
            end else if (id_opcode == OPC_LD) begin
                dec_load      = 1'b1;
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_reads_rs1 = 1'b1;
            end else if (id_opcode == OPC_ST) begin
                dec_mem_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_reads_rs1 = 1'b1;
                dec_reads_rs2 = 1'b1;
            end else if (id_opcode == OPC_JMP) begin
                dec_jump      = 1'b1;
            end else begin
                dec_illegal   = 1'b1;
            end
        end
    end

    // Hazard detection and request priority: flush beats stall beats jump squash.
    // Requests are held low while reset is asserted so upstream sees a quiet pipe.
    always_comb begin
        load_use_hit = (dec_reads_rs1 && (id_rs1 == rd_q)) ||
                       (dec_reads_rs2 && (id_rs2 == rd_q));
        flush        = !rst && ctrl_q[7] && ctrl_q[5] && ex_branch_taken;
        stall        = !rst && id_valid && ctrl_q[7] && ctrl_q[3] && load_use_hit && !flush;
        jump_flush   = !rst && id_valid && dec_jump && !stall && !flush;
    end

    // Next EX bundle: a bubble on flush or stall, otherwise the decoded ID slot.
    always_comb begin
        ctrl_d = {id_valid, dec_reg_write, dec_branch, dec_alu_src,
                  dec_load, dec_mem_write, dec_jump, dec_illegal};
        rd_d   = id_rd;
        if (flush || stall) begin
            ctrl_d = '0;
            rd_d   = '0;
        end
    end

    // Saturating event counters; a clear wins over an increment in the same cycle.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (flush && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset discards whatever instruction was in EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q      <= '0;
            rd_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            rd_q        <= rd_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_valid     = ctrl_q[7];
    assign ex_reg_write = ctrl_q[6];
    assign ex_branch    = ctrl_q[5];
    assign ex_alu_src   = ctrl_q[4];
    assign ex_load      = ctrl_q[3];
    assign ex_mem_write = ctrl_q[2];
    assign ex_jump      = ctrl_q[1];
    assign ex_illegal   = ctrl_q[0];
    assign ex_rd        = rd_q;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed testbench for pipe_control_unit. Two instances share stimulus:
// u_dut with default parameters and u_sat with 2-bit counters for saturation.
module tb_pipe_control_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       id_valid;
  logic [3:0] id_opcode;
  logic [2:0] id_rs1, id_rs2, id_rd;
  logic       ex_branch_taken;
  logic       cnt_clr;

  logic        stall, flush, jump_flush;
  logic        ex_valid, ex_reg_write, ex_branch, ex_alu_src;
  logic        ex_load, ex_mem_write, ex_jump, ex_illegal;
  logic [2:0]  ex_rd;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_stall, s_flush, s_jump_flush;
  logic        s_valid, s_reg_write, s_branch, s_alu_src;
  logic        s_load, s_mem_write, s_jump, s_illegal;
  logic [2:0]  s_rd;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  pipe_control_unit u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_branch_taken(ex_branch_taken), .cnt_clr(cnt_clr),
    .stall(stall), .flush(flush), .jump_flush(jump_flush),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_branch(ex_branch),
    .ex_alu_src(ex_alu_src), .ex_load(ex_load), .ex_mem_write(ex_mem_write),
    .ex_jump(ex_jump), .ex_illegal(ex_illegal), .ex_rd(ex_rd),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_control_unit #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_branch_taken(ex_branch_taken), .cnt_clr(cnt_clr),
    .stall(s_stall), .flush(s_flush), .jump_flush(s_jump_flush),
    .ex_valid(s_valid), .ex_reg_write(s_reg_write), .ex_branch(s_branch),
    .ex_alu_src(s_alu_src), .ex_load(s_load), .ex_mem_write(s_mem_write),
    .ex_jump(s_jump), .ex_illegal(s_illegal), .ex_rd(s_rd),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  // {valid, reg_write, branch, alu_src, load, mem_write, jump, illegal}
  logic [7:0] bundle;
  assign bundle = {ex_valid, ex_reg_write, ex_branch, ex_alu_src,
                   ex_load, ex_mem_write, ex_jump, ex_illegal};

  localparam logic [7:0] B_BUBBLE = 8'b0000_0000;
  localparam logic [7:0] B_RTYPE  = 8'b1101_0000;
  localparam logic [7:0] B_BRANCH = 8'b1011_0000;
  localparam logic [7:0] B_LOAD   = 8'b1101_1000;
  localparam logic [7:0] B_STORE  = 8'b1001_0100;
  localparam logic [7:0] B_JUMP   = 8'b1000_0010;
  localparam logic [7:0] B_ILL    = 8'b1000_0001;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [2:0] rd,
                       input logic taken, input logic clr);
    id_valid        = v;
    id_opcode       = op;
    id_rs1          = rs1;
    id_rs2          = rs2;
    id_rd           = rd;
    ex_branch_taken = taken;
    cnt_clr         = clr;
    #1;
  endtask

  function automatic logic [7:0] sweep_exp(input int op);
    if (op <= 4) return B_RTYPE;
    case (op)
      5: return B_BRANCH;
      6: return B_LOAD;
      7: return B_STORE;
      8: return B_JUMP;
      default: return B_ILL;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    // Reset with random inputs for two edges.
    rst = 1'b1;
    drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);
    tick();
    drive(1'b1, 4'd8, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
          3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);
    tick();
    check("rst_bundle", 32'(bundle), 32'(B_BUBBLE));
    check("rst_rd", 32'(ex_rd), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    check("rst_reqs", 32'({stall, flush, jump_flush}), 32'd0);
    rst = 1'b0;
    drive(1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    check("post_rst_reqs", 32'({stall, flush, jump_flush}), 32'd0);

    // Decode sweep: rd=1 never matches rs1=2/rs2=3, so no hazards.
    for (int op = 0; op < 16; op++) begin
      drive(1'b1, 4'(op), 3'd2, 3'd3, 3'd1, 1'b0, 1'b0);
      check($sformatf("sweep_stall_op%0d", op), 32'(stall), 32'd0);
      check($sformatf("sweep_jflush_op%0d", op), 32'(jump_flush), (op == 8) ? 32'd1 : 32'd0);
      exp_q.push_back(sweep_exp(op));
      tick();
      check($sformatf("sweep_bundle_op%0d", op), 32'(bundle), 32'(exp_q.pop_front()));
      check($sformatf("sweep_rd_op%0d", op), 32'(ex_rd), 32'd1);
    end

    // Load-use: LOAD rd=3 then R-type reading rs2=3.
    drive(1'b1, 4'd6, 3'd0, 3'd0, 3'd3, 1'b0, 1'b0);
    check("lu_load_nostall", 32'(stall), 32'd0);
    tick();
    drive(1'b1, 4'd0, 3'd1, 3'd3, 3'd4, 1'b0, 1'b0);
    check("lu_stall", 32'(stall), 32'd1);
    check("lu_jflush", 32'(jump_flush), 32'd0);
    tick();
    check("lu_bubble", 32'(bundle), 32'(B_BUBBLE));
    check("lu_bubble_rd", 32'(ex_rd), 32'd0);
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    check("lu_stall_once", 32'(stall), 32'd0);
    tick();
    check("lu_rtype_in_ex", 32'(bundle), 32'(B_RTYPE));
    check("lu_rtype_rd", 32'(ex_rd), 32'd4);

    // LOAD rd=3 followed by a jump: a jump reads nothing, so no stall.
    drive(1'b1, 4'd6, 3'd0, 3'd0, 3'd3, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd8, 3'd3, 3'd3, 3'd0, 1'b0, 1'b0);
    check("lu_jump_nostall", 32'(stall), 32'd0);
    check("lu_jump_jflush", 32'(jump_flush), 32'd1);
    tick();
    check("lu_jump_in_ex", 32'(bundle), 32'(B_JUMP));
    check("lu_jump_stall_cnt", 32'(stall_cnt), 32'd1);

    // Taken branch in EX while ID holds a LOAD.
    drive(1'b1, 4'd5, 3'd1, 3'd2, 3'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd6, 3'd6, 3'd0, 3'd5, 1'b1, 1'b0);
    check("br_flush", 32'(flush), 32'd1);
    check("br_nostall", 32'(stall), 32'd0);
    tick();
    check("br_bubble", 32'(bundle), 32'(B_BUBBLE));
    check("br_flush_cnt", 32'(flush_cnt), 32'd1);

    // Priority: taken branch in EX with a jump in ID.
    drive(1'b1, 4'd5, 3'd1, 3'd2, 3'd3, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd8, 3'd3, 3'd3, 3'd0, 1'b1, 1'b0);
    check("pri_reqs", 32'({stall, flush, jump_flush}), 32'b010);
    tick();
    check("pri_bubble", 32'(bundle), 32'(B_BUBBLE));
    check("pri_flush_cnt", 32'(flush_cnt), 32'd2);

    // Counter clear.
    drive(1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1);
    tick();
    check("clr_stall_cnt", 32'(stall_cnt), 32'd0);
    check("clr_flush_cnt", 32'(flush_cnt), 32'd0);
    check("clr_sat_stall_cnt", 32'(s_stall_cnt), 32'd0);

    // Five load-use stalls: 2-bit counter saturates at 3, 16-bit reaches 5.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'd6, 3'd0, 3'd0, 3'd3, 1'b0, 1'b0);
      tick();
      drive(1'b1, 4'd1, 3'd3, 3'd0, 3'd2, 1'b0, 1'b0);
      check($sformatf("sat_stall_%0d", i), 32'(stall), 32'd1);
      tick();
    end
    check("sat_cnt2", 32'(s_stall_cnt), 32'd3);
    check("sat_cnt16", 32'(stall_cnt), 32'd5);

    // Clear coinciding with a stall leaves the counter at zero.
    drive(1'b1, 4'd6, 3'd0, 3'd0, 3'd3, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd0, 3'd0, 3'd3, 3'd2, 1'b0, 1'b1);
    check("clr_stall_same", 32'(stall), 32'd1);
    tick();
    check("clr_win_cnt16", 32'(stall_cnt), 32'd0);
    check("clr_win_cnt2", 32'(s_stall_cnt), 32'd0);

    // Reset mid-stall discards the in-flight EX LOAD.
    drive(1'b1, 4'd6, 3'd0, 3'd0, 3'd3, 1'b0, 1'b0);
    tick();
    check("midrst_load_in_ex", 32'(bundle), 32'(B_LOAD));
    rst = 1'b1;
    drive(1'b1, 4'd0, 3'd0, 3'd3, 3'd2, 1'b0, 1'b0);
    check("midrst_reqs", 32'({stall, flush, jump_flush}), 32'd0);
    tick();
    check("midrst_bundle", 32'(bundle), 32'(B_BUBBLE));
    check("midrst_rd", 32'(ex_rd), 32'd0);
    rst = 1'b0;
    drive(1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    tick();

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
